masked_aes_seq_ctrl: RTL and testbench
======================================

Name: masked_aes_seq_ctrl

Overview:
- Parametrised sequencer for the share-sliced masked AES-128 datapath.
- Generalises the fixed byte-serial, two-lane control to LANES bytes per share per cycle and a configurable masked S-box pipeline latency.
- Adds load stalling, abort and a fresh-randomness request strobe.
- Drives the data/key register units and S-box input select; holds no share data itself.

Parameters:
LANES, 2, bytes per share fed to the S-box bank per cycle; legal 1, 2, 4.
SBOX_LAT, 2, masked S-box pipeline latency in cycles; legal 1..8.
ROUNDS, 10, AES rounds.

Ports:
clk  in  1  clock.
rst  in  1  synchronous active-high reset.
pk_valid  in  1  plaintext/key beat valid.
abort  in  1  synchronous cancel.
load_en  out  1  registers accept a load beat.
dochoosesboxin  out  1  1 = key bytes to S-box, 0 = state^key.
doSR  out  1  ShiftRows strobe.
doMC  out  1  MixColumns strobe.
key_reg_move  out  1  key register shift.
dokeyothercol  out  1  key columns 1..3 update.
doxorRcon  out  1  XOR Rcon into key byte.
Rcon  out  8  current round constant.
round  out  4  current round, 1..ROUNDS; 0 when idle.
rnd_req  out  1  fresh randomness consumed this cycle.
done  out  1  one-cycle completion pulse.
busy  out  1  operation in progress.

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst` is synchronous and active-high.
- Reset values: state IDLE; all strobes 0; round=0; Rcon=8'h01; done=0; busy=0.
- Derived constants: B=16/LANES (beats per state pass), K=4/LANES rounded up (key S-box beats). The beat counter is wide enough for max(B, K, SBOX_LAT).
- IDLE:
  - pk_valid=1 → LOAD. This cycle counts as beat 0: load_en=1, busy=1.
  - pk_valid=0 → stay in IDLE.
- LOAD:
  - load_en=pk_valid. The beat counter advances only on pk_valid=1; pk_valid low stalls the load without losing data.
  - After beat B-1 is accepted → KEY, with round=1.
- KEY (K cycles):
  - dochoosesboxin=1, key_reg_move=1, rnd_req=1.
  - doxorRcon=1 on the first KEY beat only.
  - Then → DATA.
- DATA (B cycles):
  - dochoosesboxin=0, rnd_req=1, key_reg_move=1.
  - Round 1 carries the initial AddRoundKey through state^key.
  - Then → DRAIN.
- DRAIN (SBOX_LAT cycles): all strobes 0. Then → UPD.
- UPD (1 cycle):
  - doSR=1 and dokeyothercol=1.
  - doMC=1 only when round<ROUNDS.
  - If round<ROUNDS: round increments, Rcon advances (xtime; 8'h80 → 8'h1B), → KEY.
  - If round=ROUNDS: → DONE.
- DONE (1 cycle):
  - done=1, busy=0; round and Rcon hold their final values.
  - Next cycle → IDLE with round=0 and Rcon=8'h01.
- busy: 1 in LOAD, KEY, DATA, DRAIN and UPD; 0 in IDLE and DONE.
- pk_valid outside IDLE/LOAD: ignored; no load_en.
- Abort:
  - abort=1 in any non-IDLE state → next cycle IDLE, with reset values on all outputs and no done.
  - abort in IDLE has no effect.
  - abort has priority over pk_valid in the same cycle.
- Latency: with pk_valid held high, done asserts exactly B + ROUNDS·(K+B+SBOX_LAT+1) cycles after the first load beat.
- rst mid-operation: identical to abort, but Rcon and round are also forced to reset values the same cycle.
- All strobes are registered-state decodes: no combinational path from pk_valid/abort to any strobe except load_en.

Test Plan:
- Reset: rst=1 for 2 cycles, then 0 → all outputs 0, Rcon=8'h01, round=0, state IDLE.
- Nominal run (LANES=2, SBOX_LAT=2, pk_valid high 8 cycles):
  - done pulses exactly 138 cycles after the first beat, for one cycle.
  - busy is high for 138 cycles.
  - Rcon at the UPD cycles is 01,02,04,08,10,20,40,80,1B,36.
  - doMC=1 in nine UPD cycles, 0 in the tenth.
  - rnd_req is high for 100 cycles.
- Load stall (LANES=2): pk_valid high 3, low 5, high 5 → load_en high exactly 8 cycles; KEY entered the cycle after the 8th accepted beat; done at 138+5.
- Abort in DATA of round 5, plus a simultaneous pk_valid+abort in IDLE-to-LOAD → busy=0 next cycle, no done pulse; a subsequent clean run completes in 138 cycles with Rcon starting at 8'h01.
- Config LANES=4, SBOX_LAT=4:
  - K=1, B=4; done 104 cycles after the first beat.
  - doxorRcon high once per round, coincident with dochoosesboxin.
- pk_valid pulsed during rounds 2–9 → no load_en, and done timing unchanged.

Source files
------------

// File: rtl/masked_aes_seq_ctrl.sv
// Control sequencer for the share-sliced masked AES-128 datapath: schedules load beats,
// key/data S-box passes, pipeline drain and the per-round ShiftRows/MixColumns update.
module masked_aes_seq_ctrl #(
    parameter int unsigned LANES    = 2,
    parameter int unsigned SBOX_LAT = 2,
    parameter int unsigned ROUNDS   = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pk_valid,
    input  logic       abort,
    output logic       load_en,
    output logic       dochoosesboxin,
    output logic       doSR,
    output logic       doMC,
    output logic       key_reg_move,
    output logic       dokeyothercol,
    output logic       doxorRcon,
    output logic [7:0] Rcon,
    output logic [3:0] round,
    output logic       rnd_req,
    output logic       done,
    output logic       busy
);

    localparam int unsigned B      = 16 / LANES;
    localparam int unsigned K      = (4 + LANES - 1) / LANES;
    localparam int unsigned BK     = (B > K) ? B : K;
    localparam int unsigned CntMax = (BK > SBOX_LAT) ? BK : SBOX_LAT;
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    localparam logic [CntW-1:0] LastLoad  = CntW'(B - 1);
    localparam logic [CntW-1:0] LastKey   = CntW'(K - 1);
    localparam logic [CntW-1:0] LastData  = CntW'(B - 1);
    localparam logic [CntW-1:0] LastDrain = CntW'(SBOX_LAT - 1);
    localparam logic [3:0]      LastRound = 4'(ROUNDS);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StKey,
        StData,
        StDrain,
        StUpd,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [3:0]      round_q, round_d;
    logic [7:0]      rcon_q, rcon_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            round_q <= '0;
            rcon_q  <= 8'h01;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            round_q <= round_d;
            rcon_q  <= rcon_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        round_d = round_q;
        rcon_d  = rcon_q;
        case (state_q)
            StIdle: begin
                // The accepting IDLE cycle is beat 0, so LOAD starts counting at 1.
                if (pk_valid && !abort) begin
                    state_d = StLoad;
                    cnt_d   = CntW'(1);
                end
            end
            StLoad: begin
                if (pk_valid) begin
                    if (cnt_q == LastLoad) begin
                        state_d = StKey;
                        cnt_d   = '0;
                        round_d = 4'd1;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
            end
            StKey: begin
                if (cnt_q == LastKey) begin
                    state_d = StData;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StData: begin
                if (cnt_q == LastData) begin
                    state_d = StDrain;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StDrain: begin
                if (cnt_q == LastDrain) begin
                    state_d = StUpd;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StUpd: begin
                if (round_q < LastRound) begin
                    state_d = StKey;
                    round_d = round_q + 4'd1;
                    // GF(2^8) doubling of the round constant.
                    rcon_d  = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1B : 8'h00);
                end else begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
                round_d = '0;
                rcon_d  = 8'h01;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (abort && (state_q != StIdle)) begin
            state_d = StIdle;
            cnt_d   = '0;
            round_d = '0;
            rcon_d  = 8'h01;
        end
    end

    // Strobes decode registered state only; load_en and IDLE busy follow the handshake.
    always_comb begin
        load_en        = 1'b0;
        dochoosesboxin = 1'b0;
        doSR           = 1'b0;
        doMC           = 1'b0;
        key_reg_move   = 1'b0;
        dokeyothercol  = 1'b0;
        doxorRcon      = 1'b0;
        rnd_req        = 1'b0;
        done           = 1'b0;
        busy           = 1'b0;
        round          = round_q;
        Rcon           = rcon_q;
        case (state_q)
            StIdle: begin
                load_en = pk_valid & ~abort;
                busy    = pk_valid & ~abort;
            end
            StLoad: begin
                load_en = pk_valid & ~abort;
                busy    = 1'b1;
            end
            StKey: begin
                dochoosesboxin = 1'b1;
                key_reg_move   = 1'b1;
                rnd_req        = 1'b1;
                doxorRcon      = (cnt_q == '0);
                busy           = 1'b1;
            end
            StData: begin
                key_reg_move = 1'b1;
                rnd_req      = 1'b1;
                busy         = 1'b1;
            end
            StDrain: begin
                busy = 1'b1;
            end
            StUpd: begin
                doSR          = 1'b1;
                dokeyothercol = 1'b1;
                doMC          = (round_q < LastRound);
                busy          = 1'b1;
            end
            StDone: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_masked_aes_seq_ctrl.sv
// Bench for masked_aes_seq_ctrl: two configurations checked every cycle against a
// schedule model, plus directed scenarios with hand-computed timing and count expectations.
module tb_masked_aes_seq_ctrl;

    localparam int R = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [1:0] pk, ab;
    logic [1:0] le, cs, sr, mc, krm, kc, xr, rr, dn, by;
    logic [3:0] rd [2];
    logic [7:0] rc [2];

    masked_aes_seq_ctrl #(.LANES(2), .SBOX_LAT(2), .ROUNDS(R)) u_a (
        .clk(clk), .rst(rst), .pk_valid(pk[0]), .abort(ab[0]), .load_en(le[0]),
        .dochoosesboxin(cs[0]), .doSR(sr[0]), .doMC(mc[0]), .key_reg_move(krm[0]),
        .dokeyothercol(kc[0]), .doxorRcon(xr[0]), .Rcon(rc[0]), .round(rd[0]),
        .rnd_req(rr[0]), .done(dn[0]), .busy(by[0])
    );

    masked_aes_seq_ctrl #(.LANES(4), .SBOX_LAT(4), .ROUNDS(R)) u_b (
        .clk(clk), .rst(rst), .pk_valid(pk[1]), .abort(ab[1]), .load_en(le[1]),
        .dochoosesboxin(cs[1]), .doSR(sr[1]), .doMC(mc[1]), .key_reg_move(krm[1]),
        .dokeyothercol(kc[1]), .doxorRcon(xr[1]), .Rcon(rc[1]), .round(rd[1]),
        .rnd_req(rr[1]), .done(dn[1]), .busy(by[1])
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Per-configuration beats: B = 16/LANES, K = ceil(4/LANES), S = SBOX_LAT.
    function automatic int cb(int d); return (d == 0) ? 8 : 4; endfunction
    function automatic int ck(int d); return (d == 0) ? 2 : 1; endfunction
    function automatic int cs_lat(int d); return (d == 0) ? 2 : 4; endfunction
    function automatic int per(int d); return ck(d) + cb(d) + cs_lat(d) + 1; endfunction

    function automatic logic [7:0] rcon_of(int r);
        case (r)
            1: return 8'h01;  2: return 8'h02;  3: return 8'h04;  4: return 8'h08;
            5: return 8'h10;  6: return 8'h20;  7: return 8'h40;  8: return 8'h80;
            9: return 8'h1B; 10: return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // Model: 0 idle, 1 loading (m_beats accepted), 2 running (m_t cycles since load end).
    int m_st [2];
    int m_beats [2];
    int m_t [2];
    bit m_valid = 1'b0;

    function automatic logic [21:0] exp_out(int d, logic p, logic a);
        logic e_le, e_cs, e_sr, e_mc, e_krm, e_kc, e_xr, e_rr, e_dn, e_by;
        logic [3:0] e_rd;
        logic [7:0] e_rc;
        int r, off;
        {e_le, e_cs, e_sr, e_mc, e_krm, e_kc, e_xr, e_rr, e_dn, e_by} = '0;
        e_rd = 4'd0;
        e_rc = 8'h01;
        if (m_st[d] == 0) begin
            e_le = p & ~a;
            e_by = p & ~a;
        end else if (m_st[d] == 1) begin
            e_le = p & ~a;
            e_by = 1'b1;
        end else if (m_t[d] == R * per(d)) begin
            e_dn = 1'b1;
            e_rd = 4'(R);
            e_rc = rcon_of(R);
        end else begin
            r    = m_t[d] / per(d);
            off  = m_t[d] % per(d);
            e_by = 1'b1;
            e_rd = 4'(r + 1);
            e_rc = rcon_of(r + 1);
            if (off < ck(d)) begin
                e_cs = 1'b1; e_krm = 1'b1; e_rr = 1'b1; e_xr = (off == 0);
            end else if (off < ck(d) + cb(d)) begin
                e_krm = 1'b1; e_rr = 1'b1;
            end else if (off == per(d) - 1) begin
                e_sr = 1'b1; e_kc = 1'b1; e_mc = (r + 1 < R);
            end
        end
        return {e_le, e_cs, e_sr, e_mc, e_krm, e_kc, e_xr, e_rr, e_dn, e_by, e_rd, e_rc};
    endfunction

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                m_st[d] = 0;
            end else if (ab[d] && m_st[d] != 0) begin
                m_st[d] = 0;
            end else if (m_st[d] == 0) begin
                if (pk[d] && !ab[d]) begin
                    m_st[d]    = 1;
                    m_beats[d] = 1;
                end
            end else if (m_st[d] == 1) begin
                if (pk[d]) begin
                    m_beats[d]++;
                    if (m_beats[d] == cb(d)) begin
                        m_st[d] = 2;
                        m_t[d]  = 0;
                    end
                end
            end else if (m_t[d] == R * per(d)) begin
                m_st[d] = 0;
            end else begin
                m_t[d]++;
            end
        end
        if (rst) m_valid = 1'b1;
    end

    always @(negedge clk) begin
        if (m_valid) begin
            for (int d = 0; d < 2; d++) begin
                logic [21:0] e, act;
                e   = exp_out(d, pk[d], ab[d]);
                act = {le[d], cs[d], sr[d], mc[d], krm[d], kc[d], xr[d], rr[d], dn[d], by[d],
                       rd[d], rc[d]};
                n_tests++;
                if (act !== e) begin
                    n_fail++;
                    $display("FAIL model_cycle dut%0d @%0t: got %h, want %h", d, $time, act, e);
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    int s_done_off, s_done_n, s_busy, s_rnd, s_mc, s_le, s_xor, s_xor_bad, s_key_off;
    int s_abort_k, s_busy_after;
    logic [7:0] s_rcon_q [$];

    // mode 0 nominal, 1 load stall, 2 pk pulses mid-run, 3 abort in round-5 DATA.
    task automatic run(input int d, input int mode, input int max_cyc);
        int  last_rd;
        bit  last_data, aborted;
        logic p, a;
        last_rd = 0; last_data = 1'b0; aborted = 1'b0;
        s_done_off = -1; s_done_n = 0; s_busy = 0; s_rnd = 0; s_mc = 0; s_le = 0;
        s_xor = 0; s_xor_bad = 0; s_key_off = -1; s_abort_k = -1; s_busy_after = -1;
        s_rcon_q.delete();
        for (int k = 0; k < max_cyc; k++) begin
            a = 1'b0;
            case (mode)
                1:       p = (k < 3) || (k >= 8 && k < 13);
                2:       p = (k < cb(d)) || (last_rd >= 2 && last_rd <= 9 && (k % 3 == 0));
                default: p = (k < cb(d));
            endcase
            if (mode == 3 && !aborted && last_rd == 5 && last_data) begin
                a = 1'b1;
                aborted = 1'b1;
                s_abort_k = k;
            end
            pk[d] = p;
            ab[d] = a;
            @(negedge clk);
            if (le[d]) s_le++;
            if (by[d]) s_busy++;
            if (rr[d]) s_rnd++;
            if (sr[d]) begin
                s_rcon_q.push_back(rc[d]);
                if (mc[d]) s_mc++;
            end
            if (xr[d]) begin
                s_xor++;
                if (!cs[d]) s_xor_bad++;
            end
            if (cs[d] && s_key_off < 0) s_key_off = k;
            if (dn[d]) begin
                s_done_n++;
                if (s_done_off < 0) s_done_off = k;
            end
            if (s_abort_k >= 0 && k == s_abort_k + 1) s_busy_after = int'(by[d]);
            last_rd   = int'(rd[d]);
            last_data = rr[d] && !cs[d];
            @(posedge clk);
            #1;
            if (mode != 3 && s_done_off >= 0) break;
        end
        pk[d] = 1'b0;
        ab[d] = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        pk  = '0;
        ab  = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_strobes", int'({le[0], cs[0], sr[0], mc[0], krm[0], kc[0], xr[0], rr[0],
                                     dn[0], by[0]}), 0);
        check("reset_round", int'(rd[0]), 0);
        check("reset_rcon", int'(rc[0]), 8'h01);
        @(posedge clk);
        #1;

        run(0, 0, 300);
        check("nom_done_latency", s_done_off, 138);
        check("nom_done_pulses", s_done_n, 1);
        check("nom_busy_cycles", s_busy, 138);
        check("nom_rnd_req_cycles", s_rnd, 100);
        check("nom_domc_count", s_mc, 9);
        check("nom_load_en_count", s_le, 8);
        check("nom_upd_count", s_rcon_q.size(), 10);
        for (int i = 0; i < s_rcon_q.size() && i < 10; i++) begin
            check($sformatf("nom_rcon_upd%0d", i + 1), int'(s_rcon_q[i]), int'(rcon_of(i + 1)));
        end
        repeat (2) @(posedge clk);
        #1;

        run(0, 1, 300);
        check("stall_load_en_count", s_le, 8);
        check("stall_key_entry", s_key_off, 13);
        check("stall_done_latency", s_done_off, 143);

        run(0, 3, 120);
        check("abort_seen", int'(s_abort_k > 0), 1);
        check("abort_busy_next", s_busy_after, 0);
        check("abort_no_done", s_done_n, 0);
        pk[0] = 1'b1;
        ab[0] = 1'b1;
        @(negedge clk);
        check("idle_abort_load_en", int'(le[0]), 0);
        check("idle_abort_busy", int'(by[0]), 0);
        @(posedge clk);
        #1;
        pk[0] = 1'b0;
        ab[0] = 1'b0;
        @(negedge clk);
        check("idle_abort_busy_next", int'(by[0]), 0);
        @(posedge clk);
        #1;
        run(0, 0, 300);
        check("post_abort_done_latency", s_done_off, 138);
        check("post_abort_first_rcon", (s_rcon_q.size() > 0) ? int'(s_rcon_q[0]) : -1, 8'h01);

        run(0, 2, 300);
        check("pulse_load_en_count", s_le, 8);
        check("pulse_done_latency", s_done_off, 138);

        run(1, 0, 300);
        check("l4_done_latency", s_done_off, 104);
        check("l4_busy_cycles", s_busy, 104);
        check("l4_xorrcon_count", s_xor, 10);
        check("l4_xorrcon_without_sel", s_xor_bad, 0);
        check("l4_rnd_req_cycles", s_rnd, 50);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
